// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_AW     = 32;
  localparam int DEF_DW     = 32;
  localparam int DEF_RD_LAT = 1;

  // Arbiter sequencing states; exported on the top's debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Which requester owns the memory for the current access.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant select for the memory port arbiter.
// Build option MEMARB_RR_EN: on a tie, grant the requester not served last;
// otherwise data always wins a tie. A lone requester always wins.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic   iIReq,
  input  logic   iDReq,
  input  owner_t iLastOwner,
  output logic   oGrantValid,
  output owner_t oGrantOwner
);

  owner_t tieOwner;

`ifdef MEMARB_RR_EN
  assign tieOwner = (iLastOwner == OWN_D) ? OWN_I : OWN_D;
`else
  logic unusedLastOwner;
  assign unusedLastOwner = iLastOwner;
  assign tieOwner = OWN_D;
`endif

  // Pick the owner of the next access from the pending requests.
  always_comb begin
    oGrantValid = iIReq | iDReq;
    oGrantOwner = OWN_I;
    if (iIReq && iDReq) begin
      oGrantOwner = tieOwner;
    end else if (iDReq) begin
      oGrantOwner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between the fetch and the
// load/store requesters, one access at a time.
// Build option MEMARB_RR_EN selects round-robin tie-breaking (see mem_arb_sel).
//
// Handshake: a requester raises its req with stable address (and store data/we)
// and holds it until its ack pulse. The ack is high for exactly one cycle; a req
// still high during that ack cycle is taken as a brand-new request, so the
// requester drops req in the ack cycle unless it wants another access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iIReq,
  input  logic [AW-1:0] iIAddr,
  output logic          oIAck,
  output logic [DW-1:0] oInstr,
  input  logic          iDReq,
  input  logic          iDWe,
  input  logic [AW-1:0] iDAddr,
  input  logic [DW-1:0] iDWData,
  output logic          oDAck,
  output logic [DW-1:0] oDRData,
  output logic [AW-1:0] oMemAddr,
  output logic [DW-1:0] oMemWData,
  output logic          oMemWe,
  output logic          oMemRe,
  input  logic [DW-1:0] iMemRData,
  output logic          oBusy,
  output arb_state_t    oDbgState
);

  // Remaining wait edges after the memory samples a read (RD_LAT is 1..3).
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  arb_state_t stateQ, stateNext;
  owner_t     ownerQ, lastOwnerQ, grantOwner;
  logic [1:0] cntQ;
  logic       grantValid;
  logic       doGrant, finish, capture;

  mem_arb_sel uSel (
    .iIReq       (iIReq),
    .iDReq       (iDReq),
    .iLastOwner  (lastOwnerQ),
    .oGrantValid (grantValid),
    .oGrantOwner (grantOwner)
  );

  // Next-state logic: arbitrate in IDLE/DONE, one issue cycle, then wait out the read.
  always_comb begin
    stateNext = stateQ;
    doGrant   = 1'b0;
    finish    = 1'b0;
    capture   = 1'b0;
    case (stateQ)
      ST_IDLE, ST_DONE: begin
        if (grantValid) begin
          doGrant   = 1'b1;
          stateNext = ST_ISSUE;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // oMemWe is only ever set for a granted store, so it tells the two apart.
        if (oMemWe) begin
          stateNext = ST_DONE;
          finish    = 1'b1;
        end else begin
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cntQ == 2'd0) begin
          stateNext = ST_DONE;
          finish    = 1'b1;
          capture   = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight without an ack.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Datapath: latch the granted request, time the read, return data and acks.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ownerQ     <= OWN_I;
      lastOwnerQ <= OWN_I;
      cntQ       <= 2'd0;
      oMemAddr   <= '0;
      oMemWData  <= '0;
      oMemWe     <= 1'b0;
      oMemRe     <= 1'b0;
      oIAck      <= 1'b0;
      oDAck      <= 1'b0;
      oInstr     <= '0;
      oDRData    <= '0;
    end else begin
      oIAck <= finish && (ownerQ == OWN_I);
      oDAck <= finish && (ownerQ == OWN_D);

      if (doGrant) begin
        ownerQ     <= grantOwner;
        lastOwnerQ <= grantOwner;
        if (grantOwner == OWN_D) begin
          oMemAddr  <= iDAddr;
          oMemWData <= iDWData;
          oMemWe    <= iDWe;
          oMemRe    <= ~iDWe;
        end else begin
          oMemAddr  <= iIAddr;
          oMemWe    <= 1'b0;
          oMemRe    <= 1'b1;
        end
      end else begin
        // Strobes live only for the ISSUE cycle that follows a grant.
        oMemWe <= 1'b0;
        oMemRe <= 1'b0;
      end

      if (stateQ == ST_ISSUE) begin
        cntQ <= LAT_INIT;
      end else if ((stateQ == ST_WAIT) && (cntQ != 2'd0)) begin
        cntQ <= cntQ - 2'd1;
      end

      if (capture) begin
        if (ownerQ == OWN_I) begin
          oInstr <= iMemRData;
        end else begin
          oDRData <= iMemRData;
        end
      end
    end
  end

  assign oBusy     = (stateQ == ST_ISSUE) || (stateQ == ST_WAIT);
  assign oDbgState = stateQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized fetch/load/store traffic against a cycle-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT      = 1;
  localparam int RAND_TXN = 200;

  // ---------------- clock / reset ----------------
  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  logic iRST;

  // main DUT (RD_LAT = 1)
  logic        iIReq, oIAck;
  logic [31:0] iIAddr, oInstr;
  logic        iDReq, iDWe, oDAck;
  logic [31:0] iDAddr, iDWData, oDRData;
  logic [31:0] oMemAddr, oMemWData, iMemRData;
  logic        oMemWe, oMemRe, oBusy;
  arb_state_t  oDbgState;

  // second DUT (RD_LAT = 3), fetch-only
  logic        i3Req, o3IAck, o3DAck, o3MemWe, o3MemRe, o3Busy;
  logic [31:0] i3Addr, o3Instr, o3DRData, o3MemAddr, o3MemWData, i3MemRData;
  arb_state_t  o3DbgState;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) u_dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIReq(iIReq), .iIAddr(iIAddr), .oIAck(oIAck), .oInstr(oInstr),
    .iDReq(iDReq), .iDWe(iDWe), .iDAddr(iDAddr), .iDWData(iDWData),
    .oDAck(oDAck), .oDRData(oDRData),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemWe(oMemWe), .oMemRe(oMemRe),
    .iMemRData(iMemRData), .oBusy(oBusy), .oDbgState(oDbgState)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
    .iCLK(iCLK), .iRST(iRST),
    .iIReq(i3Req), .iIAddr(i3Addr), .oIAck(o3IAck), .oInstr(o3Instr),
    .iDReq(1'b0), .iDWe(1'b0), .iDAddr(32'd0), .iDWData(32'd0),
    .oDAck(o3DAck), .oDRData(o3DRData),
    .oMemAddr(o3MemAddr), .oMemWData(o3MemWData), .oMemWe(o3MemWe), .oMemRe(o3MemRe),
    .iMemRData(i3MemRData), .oBusy(o3Busy), .oDbgState(o3DbgState)
  );

  // ---------------- memory environment ----------------
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_pipe1;
  logic [31:0] rd_pipe3 [3];

  always @(posedge iCLK) begin
    if (oMemWe) env_mem[oMemAddr[9:2]] = oMemWData;
    if (oMemRe) rd_pipe1 <= env_mem[oMemAddr[9:2]];
    if (o3MemRe) rd_pipe3[0] <= env_mem[o3MemAddr[9:2]];
    rd_pipe3[1] <= rd_pipe3[0];
    rd_pipe3[2] <= rd_pipe3[1];
  end
  assign iMemRData  = rd_pipe1;
  assign i3MemRData = rd_pipe3[2];

  // ---------------- scoreboard counters ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a grant at edge g puts the strobe out for the cycle after g,
  // keeps the port busy until the ack edge g+1 (store) or g+1+LAT (read), and the
  // port is free to grant again only on the edge after the ack edge.
  int          edge_n = 0;
  bit          model_ok = 1'b0;
  bit          m_on, m_last_d, m_d, m_we;
  int          m_grant, m_ack;
  logic [31:0] m_data;
  logic [31:0] exp_addr, exp_wdata, exp_instr, exp_drdata;
  logic        exp_re, exp_we, exp_iack, exp_dack, exp_busy;

  always @(posedge iCLK) begin
    edge_n++;
    if (iRST) begin
      model_ok = 1'b1;
      m_on = 1'b0; m_last_d = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_instr = '0; exp_drdata = '0;
      exp_re = 1'b0; exp_we = 1'b0; exp_iack = 1'b0; exp_dack = 1'b0; exp_busy = 1'b0;
    end else begin
      if ((!m_on || edge_n > m_ack) && (iIReq || iDReq)) begin
        if (iIReq && iDReq) begin
`ifdef MEMARB_RR_EN
          m_d = !m_last_d;
`else
          m_d = 1'b1;
`endif
        end else begin
          m_d = iDReq;
        end
        m_last_d = m_d;
        m_on     = 1'b1;
        m_grant  = edge_n;
        if (m_d) begin
          m_we      = iDWe;
          exp_addr  = iDAddr;
          exp_wdata = iDWData;
          if (iDWe) ref_mem[iDAddr[9:2]] = iDWData;
          else      m_data = ref_mem[iDAddr[9:2]];
        end else begin
          m_we     = 1'b0;
          exp_addr = iIAddr;
          m_data   = ref_mem[iIAddr[9:2]];
        end
        m_ack = edge_n + (m_we ? 1 : 1 + LAT);
      end
      exp_re   = m_on && (edge_n == m_grant) && !m_we;
      exp_we   = m_on && (edge_n == m_grant) && m_we;
      exp_busy = m_on && (edge_n >= m_grant) && (edge_n < m_ack);
      exp_iack = m_on && (edge_n == m_ack) && !m_d;
      exp_dack = m_on && (edge_n == m_ack) && m_d;
      if (exp_iack) exp_instr = m_data;
      if (exp_dack && !m_we) exp_drdata = m_data;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge iCLK) begin
    if (model_ok) begin
      check("mem_addr",  oMemAddr,  exp_addr);
      check("mem_wdata", oMemWData, exp_wdata);
      check("mem_re",    oMemRe,    exp_re);
      check("mem_we",    oMemWe,    exp_we);
      check("busy",      oBusy,     exp_busy);
      check("i_ack",     oIAck,     exp_iack);
      check("d_ack",     oDAck,     exp_dack);
      check("instr",     oInstr,    exp_instr);
      check("d_rdata",   oDRData,   exp_drdata);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- random drivers ----------------
  bit rand_phase = 1'b0;
  bit i_done = 1'b0;
  bit d_done = 1'b0;

  initial begin : drv_fetch
    bit hold;
    int w;
    hold = 1'b0;
    wait (rand_phase);
    for (int k = 0; k < RAND_TXN; k++) begin
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge iCLK);
      iIAddr = $urandom_range(0, 31) << 2;
      iIReq  = 1'b1;
      w = 0;
      do begin
        @(negedge iCLK);
        w++;
      end while (!oIAck && w < 100);
      check("rand_fetch_ack_seen", oIAck, 1'b1);
      hold = ($urandom_range(0, 3) == 0);
      if (!hold) iIReq = 1'b0;
    end
    iIReq  = 1'b0;
    i_done = 1'b1;
  end

  initial begin : drv_data
    bit hold;
    int w;
    hold = 1'b0;
    wait (rand_phase);
    for (int k = 0; k < RAND_TXN; k++) begin
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge iCLK);
      iDWe    = ($urandom_range(0, 1) == 1);
      iDAddr  = $urandom_range(0, 31) << 2;
      iDWData = $urandom;
      iDReq   = 1'b1;
      w = 0;
      do begin
        @(negedge iCLK);
        w++;
      end while (!oDAck && w < 100);
      check("rand_data_ack_seen", oDAck, 1'b1);
      hold = ($urandom_range(0, 3) == 0);
      if (!hold) iDReq = 1'b0;
    end
    iDReq  = 1'b0;
    d_done = 1'b1;
  end

  // ---------------- directed scenarios ----------------
  int          n_a, n_b, cnt_a, cnt_b;
  logic [31:0] val_a, val_b, we_addr, we_data;

  initial begin : main
    logic [31:0] v;
    iRST = 1'b1;
    iIReq = 1'b0; iIAddr = '0;
    iDReq = 1'b0; iDWe = 1'b0; iDAddr = '0; iDWData = '0;
    i3Req = 1'b0; i3Addr = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[0]  = 32'h00052283; ref_mem[0]  = 32'h00052283;
    env_mem[1]  = 32'h0045a303; ref_mem[1]  = 32'h0045a303;
    env_mem[20] = 32'h00000001; ref_mem[20] = 32'h00000001;

    repeat (3) @(negedge iCLK);
    check("rst_state",  oDbgState, ST_IDLE);
    check("rst_iack",   oIAck,     1'b0);
    check("rst_dack",   oDAck,     1'b0);
    check("rst_busy",   oBusy,     1'b0);
    check("rst_memre",  oMemRe,    1'b0);
    check("rst_memwe",  oMemWe,    1'b0);
    check("rst_addr",   oMemAddr,  32'h0);
    check("rst_instr",  oInstr,    32'h0);
    check("rst_drdata", oDRData,   32'h0);
    iRST = 1'b0;

    // 1: fetch only
    @(negedge iCLK);
    iIAddr = 32'h0; iIReq = 1'b1;
    n_a = 0; cnt_a = 0; cnt_b = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge iCLK);
      if (oMemRe) cnt_a++;
      if (oDAck)  cnt_b++;
      if (oIAck) begin n_a = n; val_a = oInstr; iIReq = 1'b0; break; end
    end
    check("t1_ack_edges", n_a,   3);
    check("t1_instr",     val_a, 32'h00052283);
    check("t1_re_cycles", cnt_a, 1);
    check("t1_no_dack",   cnt_b, 0);

    // 2: load and fetch on the same edge, data first
    @(negedge iCLK);
    iDWe = 1'b0; iDAddr = 32'h50; iIAddr = 32'h4;
    iDReq = 1'b1; iIReq = 1'b1;
    n_a = 0; n_b = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge iCLK);
      if (oDAck && n_a == 0) begin n_a = n; val_a = oDRData; iDReq = 1'b0; end
      if (oIAck && n_b == 0) begin n_b = n; val_b = oInstr;  iIReq = 1'b0; end
      if (n_a != 0 && n_b != 0) break;
    end
    check("t2_dack_edges", n_a,   3);
    check("t2_iack_edges", n_b,   6);
    check("t2_load_data",  val_a, 32'h1);
    check("t2_fetch_data", val_b, 32'h0045a303);

    // 3: store, then load it back
    @(negedge iCLK);
    iDWe = 1'b1; iDAddr = 32'h60; iDWData = 32'hB; iDReq = 1'b1;
    n_a = 0; cnt_a = 0; we_addr = '0; we_data = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge iCLK);
      if (oMemWe) begin cnt_a++; we_addr = oMemAddr; we_data = oMemWData; end
      if (oDAck) begin n_a = n; iDReq = 1'b0; break; end
    end
    check("t3_store_ack_edges", n_a,     2);
    check("t3_we_cycles",       cnt_a,   1);
    check("t3_we_addr",         we_addr, 32'h60);
    check("t3_we_data",         we_data, 32'hB);
    @(negedge iCLK);
    iDWe = 1'b0; iDReq = 1'b1;
    n_a = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge iCLK);
      if (oDAck) begin n_a = n; val_a = oDRData; iDReq = 1'b0; break; end
    end
    check("t3_load_ack_edges", n_a,   3);
    check("t3_load_back",      val_a, 32'hB);

    // 4: back-to-back loads with req held through the ack cycle
    @(negedge iCLK);
    iDWe = 1'b0; iDAddr = 32'h50; iDReq = 1'b1;
    n_a = 0; n_b = 0; cnt_a = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge iCLK);
      if (n_a != 0 && n == n_a + 1 && oBusy) cnt_a = 1;
      if (oDAck && n_a == 0) begin n_a = n; val_a = oDRData; iDAddr = 32'h0; end
      else if (oDAck) begin n_b = n; val_b = oDRData; iDReq = 1'b0; break; end
    end
    check("t4_first_ack",   n_a,   3);
    check("t4_second_ack",  n_b,   6);
    check("t4_no_idle",     cnt_a, 1);
    check("t4_first_data",  val_a, 32'h1);
    check("t4_second_data", val_b, 32'h00052283);

    // 5: reset while a fetch is waiting on memory
    @(negedge iCLK);
    iIAddr = 32'h4; iIReq = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    check("t5_in_wait", oDbgState, ST_WAIT);
    iRST = 1'b1; iIReq = 1'b0;
    @(negedge iCLK);
    check("t5_state", oDbgState, ST_IDLE);
    check("t5_iack",  oIAck,     1'b0);
    check("t5_busy",  oBusy,     1'b0);
    check("t5_instr", oInstr,    32'h0);
    check("t5_drdata", oDRData,  32'h0);
    check("t5_addr",  oMemAddr,  32'h0);
    check("t5_wdata", oMemWData, 32'h0);
    iRST = 1'b0;
    cnt_a = 0;
    repeat (4) begin
      @(negedge iCLK);
      if (oIAck) cnt_a++;
    end
    check("t5_no_late_ack", cnt_a, 0);

    // 6: RD_LAT = 3 instance
    @(negedge iCLK);
    i3Addr = 32'h4; i3Req = 1'b1;
    n_a = 0; cnt_a = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge iCLK);
      if (o3Busy) cnt_a++;
      if (o3IAck) begin n_a = n; val_a = o3Instr; i3Req = 1'b0; break; end
    end
    check("t6_ack_edges",  n_a,   5);
    check("t6_instr",      val_a, 32'h0045a303);
    check("t6_busy_cycles", cnt_a, 4);

    // random traffic
    @(negedge iCLK);
    rand_phase = 1'b1;
    wait (i_done && d_done);
    repeat (6) @(negedge iCLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
